// File: rtl/dac_pkg.sv
// Shared constants and state encoding for the MCP47FEB DAC update scheduler.
package dac_pkg;

    localparam logic [6:0] MCP47FEB_ADDR = 7'h60;

    localparam logic [4:0] REG_DAC0 = 5'd0;
    localparam logic [4:0] REG_DAC1 = 5'd1;

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b11;

    // WAIT down-counter load: terminal count reached on the second WAIT cycle
    localparam logic [1:0] WAIT_TC_LOAD = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_B0   = 3'd2,
        ST_B1   = 3'd3,
        ST_B2   = 3'd4,
        ST_WAIT = 3'd5,
        ST_DONE = 3'd6
    } dac_state_e;

    function automatic logic [7:0] dac_write_cmd_byte(input logic ch);
        return {(ch ? REG_DAC1 : REG_DAC0), CMD_WRITE, 1'b0};
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Two-requester round-robin arbiter: on contention, grants the channel not served last.
module dac_rr_arbiter (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        if (&req_i) begin
            gnt_o = ~last_i;
        end else begin
            gnt_o = req_i[1];
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// Shares one MCP47FEB I2C DAC between two channels: coalesces updates, arbitrates
// round-robin and drives one i2c_master write transaction per update, with NACK retry.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending channels
// CMD   | present start/write_multiple/stop command to i2c_master
// B0    | register index / write command byte
// B1    | value high byte
// B2    | value low byte (last)
// WAIT  | let i2c_master finish the bus transaction
// DONE  | resolve ACK outcome: finish, retry or flag error
module dac_update_scheduler
    import dac_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = MCP47FEB_ADDR,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ch0_value,
    input  logic        ch0_wr,
    input  logic [15:0] ch1_value,
    input  logic        ch1_wr,
    input  logic        err_clr,
    output logic [1:0]  pending,
    output logic        busy,
    output logic [1:0]  err_ack,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  data_in,
    output logic        data_in_valid,
    output logic        data_in_last,
    input  logic        data_in_ready,
    input  logic        i2c_busy,
    input  logic        missed_ack
);

    dac_state_e  state_q;
    logic        gnt_q;
    logic        rr_q;
    logic        nack_q;
    logic [15:0] tx_q;
    logic [15:0] hold0_q;
    logic [15:0] hold1_q;
    logic [1:0]  pending_q;
    logic [1:0]  pending_d;
    logic [1:0]  err_q;
    logic [1:0]  err_d;
    logic [1:0]  wait_q;
    logic [7:0]  retry_q;
    logic        busy_q;
    logic        cmd_valid_q;
    logic        cmd_flags_q;
    logic [6:0]  cmd_addr_q;
    logic [7:0]  data_q;
    logic        dvalid_q;
    logic        dlast_q;

    logic        arb_gnt;
    logic        arb_valid;
    logic        grant_fire;
    logic        done_fire;
    logic        retry_ok;

    dac_rr_arbiter u_arb (
        .req_i   (pending_q),
        .last_i  (rr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    assign grant_fire = (state_q == ST_IDLE) && arb_valid;
    assign done_fire  = (state_q == ST_DONE);
    assign retry_ok   = ({24'd0, retry_q} < MAX_RETRY);

    // New writes are applied last so they win over the grant clear.
    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        if (grant_fire) begin
            pending_d[arb_gnt] = 1'b0;
        end
        if (err_clr) begin
            err_d = 2'b00;
        end
        if (done_fire && nack_q) begin
            if (retry_ok) begin
                pending_d[gnt_q] = 1'b1;
            end else begin
                err_d[gnt_q] = 1'b1;
            end
        end
        if (ch0_wr) begin
            pending_d[0] = 1'b1;
        end
        if (ch1_wr) begin
            pending_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 2'b00;
            err_q     <= 2'b00;
            hold0_q   <= 16'h0000;
            hold1_q   <= 16'h0000;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
            if (ch0_wr) begin
                hold0_q <= ch0_value;
            end
            if (ch1_wr) begin
                hold1_q <= ch1_value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            rr_q        <= 1'b0;
            nack_q      <= 1'b0;
            tx_q        <= 16'h0000;
            wait_q      <= 2'd0;
            retry_q     <= 8'd0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_flags_q <= 1'b0;
            cmd_addr_q  <= 7'd0;
            data_q      <= 8'd0;
            dvalid_q    <= 1'b0;
            dlast_q     <= 1'b0;
        end else begin
            if (missed_ack && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
                nack_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_q     <= ST_CMD;
                        gnt_q       <= arb_gnt;
                        tx_q        <= arb_gnt ? hold1_q : hold0_q;
                        busy_q      <= 1'b1;
                        cmd_valid_q <= 1'b1;
                        cmd_flags_q <= 1'b1;
                        cmd_addr_q  <= DEV_ADDR;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        state_q     <= ST_B0;
                        cmd_valid_q <= 1'b0;
                        cmd_flags_q <= 1'b0;
                        cmd_addr_q  <= 7'd0;
                        data_q      <= dac_write_cmd_byte(gnt_q);
                        dvalid_q    <= 1'b1;
                    end
                end
                ST_B0: begin
                    if (data_in_ready) begin
                        state_q <= ST_B1;
                        data_q  <= tx_q[15:8];
                    end
                end
                ST_B1: begin
                    if (data_in_ready) begin
                        state_q <= ST_B2;
                        data_q  <= tx_q[7:0];
                        dlast_q <= 1'b1;
                    end
                end
                ST_B2: begin
                    if (data_in_ready) begin
                        state_q  <= ST_WAIT;
                        data_q   <= 8'd0;
                        dvalid_q <= 1'b0;
                        dlast_q  <= 1'b0;
                        wait_q   <= WAIT_TC_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_q != 2'd0) begin
                        wait_q <= wait_q - 2'd1;
                    end else if (!i2c_busy) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    nack_q  <= 1'b0;
                    if (nack_q && retry_ok) begin
                        retry_q <= retry_q + 8'd1;
                    end else begin
                        retry_q <= 8'd0;
                        rr_q    <= gnt_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pending            = pending_q;
    assign busy               = busy_q;
    assign err_ack            = err_q;
    assign cmd_address        = cmd_addr_q;
    assign cmd_start          = cmd_flags_q;
    assign cmd_write_multiple = cmd_flags_q;
    assign cmd_stop           = cmd_flags_q;
    assign cmd_valid          = cmd_valid_q;
    assign data_in            = data_q;
    assign data_in_valid      = dvalid_q;
    assign data_in_last       = dlast_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler with a hand-driven i2c_master handshake model.
module tb_dac_update_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ch0_value, ch1_value;
    logic        ch0_wr, ch1_wr, err_clr;
    logic [1:0]  pending, err_ack;
    logic        busy;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_write_multiple, cmd_stop, cmd_valid, cmd_ready;
    logic [7:0]  data_in;
    logic        data_in_valid, data_in_last, data_in_ready;
    logic        i2c_busy, missed_ack;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dac_update_scheduler #(
        .DEV_ADDR  (7'h60),
        .MAX_RETRY (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ch0_value          (ch0_value),
        .ch0_wr             (ch0_wr),
        .ch1_value          (ch1_value),
        .ch1_wr             (ch1_wr),
        .err_clr            (err_clr),
        .pending            (pending),
        .busy               (busy),
        .err_ack            (err_ack),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .data_in            (data_in),
        .data_in_valid      (data_in_valid),
        .data_in_last       (data_in_last),
        .data_in_ready      (data_in_ready),
        .i2c_busy           (i2c_busy),
        .missed_ack         (missed_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, pending, busy, err_ack, cmd_address, cmd_start, cmd_write_multiple,
                cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last};
    endfunction

    // Expect one write transaction; optional NACK, B1 stall, B1 mid-writes, abort in B1,
    // i2c_busy hold after the last byte and the hand-computed WAIT..IDLE tail length.
    task automatic expect_txn(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic nack, input int stall,
                              input logic [1:0] mid_mask, input logic [15:0] mid0,
                              input logic [15:0] mid1, input logic abort,
                              input int hold, input int exp_tail);
        int n;
        logic [7:0] exp_b;
        n = 0;
        while (!cmd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cmd"}, {cmd_valid, cmd_address, cmd_start, cmd_write_multiple,
                              cmd_stop, data_in_valid}, {1'b1, 7'h60, 3'b111, 1'b0});
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check({tag, "_cmd_drop"}, {cmd_valid, cmd_start, cmd_stop}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!data_in_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            exp_b = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
            check($sformatf("%s_b%0d", tag, i), {data_in_valid, data_in_last, data_in},
                  {1'b1, (i == 2), exp_b});
            if (i == 1) begin
                if (abort) return;
                if (mid_mask[0]) begin ch0_value = mid0; ch0_wr = 1'b1; end
                if (mid_mask[1]) begin ch1_value = mid1; ch1_wr = 1'b1; end
                if (stall > 0) begin
                    data_in_ready = 1'b0;
                    for (int s = 0; s < stall; s++) begin
                        @(negedge clk);
                        ch0_wr = 1'b0;
                        ch1_wr = 1'b0;
                        check($sformatf("%s_stall%0d", tag, s),
                              {data_in_valid, data_in_last, data_in}, {2'b10, b1});
                    end
                    data_in_ready = 1'b1;
                end
            end
            if (i == 2) begin
                if (nack) missed_ack = 1'b1;
                if (hold > 0) i2c_busy = 1'b1;
            end
            @(negedge clk);
            ch0_wr     = 1'b0;
            ch1_wr     = 1'b0;
            missed_ack = 1'b0;
        end
        n = 0;
        while (busy && n < 40) begin
            if (n == hold) i2c_busy = 1'b0;
            @(negedge clk);
            n++;
        end
        i2c_busy = 1'b0;
        check({tag, "_tail"}, n, exp_tail);
        check({tag, "_idle"}, {busy, data_in_valid, cmd_valid}, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0;
        ch0_value = '0; ch1_value = '0; ch0_wr = 0; ch1_wr = 0; err_clr = 0;
        cmd_ready = 0; data_in_ready = 1; i2c_busy = 0; missed_ack = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write
        ch0_value = 16'h0ABC; ch0_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0;
        check("t1_pend", {pending, busy}, 3'b010);
        expect_txn("t1", 8'h00, 8'h0A, 8'hBC, 0, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t1_after", {pending, err_ack}, 4'b0000);

        // coalescing on CH1 behind a CH0 transaction; i2c_busy extends WAIT
        ch0_value = 16'h0555; ch0_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0; ch1_value = 16'h1111; ch1_wr = 1'b1;
        @(negedge clk);
        ch1_value = 16'h2222;
        @(negedge clk);
        ch1_wr = 1'b0;
        check("t2_pend", pending, 2'b10);
        expect_txn("t2a", 8'h00, 8'h05, 8'h55, 0, 0, 2'b00, 0, 0, 0, 4, 6);
        expect_txn("t2b", 8'h08, 8'h22, 8'h22, 0, 0, 2'b00, 0, 0, 0, 0, 3);
        repeat (4) @(negedge clk);
        check("t2_quiet", {pending, busy}, 3'b000);

        // round-robin: last served CH1, so CH0 first; repeat pair during CH0 -> CH1 next
        ch0_value = 16'h0001; ch1_value = 16'h0002; ch0_wr = 1'b1; ch1_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0; ch1_wr = 1'b0;
        check("t3_pend", pending, 2'b11);
        expect_txn("t3a", 8'h00, 8'h00, 8'h01, 0, 0, 2'b11, 16'h0001, 16'h0002, 0, 0, 3);
        expect_txn("t3b", 8'h08, 8'h00, 8'h02, 0, 0, 2'b00, 0, 0, 0, 0, 3);
        expect_txn("t3c", 8'h00, 8'h00, 8'h01, 0, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t3_after", pending, 2'b00);

        // mid-transaction write does not disturb tx
        ch0_value = 16'h0ABC; ch0_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0;
        expect_txn("t4a", 8'h00, 8'h0A, 8'hBC, 0, 0, 2'b01, 16'h0123, 0, 0, 0, 3);
        expect_txn("t4b", 8'h00, 8'h01, 8'h23, 0, 0, 2'b00, 0, 0, 0, 0, 3);

        // backpressure in B1
        ch1_value = 16'h3C5A; ch1_wr = 1'b1;
        @(negedge clk);
        ch1_wr = 1'b0;
        expect_txn("t5", 8'h08, 8'h3C, 8'h5A, 0, 5, 2'b00, 0, 0, 0, 0, 3);

        // NACK on every attempt: 1 try + 2 retries, then sticky error
        ch0_value = 16'h0777; ch0_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0;
        expect_txn("t6a", 8'h00, 8'h07, 8'h77, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t6a_retry", {pending, err_ack}, 4'b0100);
        expect_txn("t6b", 8'h00, 8'h07, 8'h77, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t6b_retry", {pending, err_ack}, 4'b0100);
        expect_txn("t6c", 8'h00, 8'h07, 8'h77, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t6c_err", {pending, err_ack}, 4'b0001);
        repeat (3) @(negedge clk);
        check("t6_sticky", {busy, err_ack}, 3'b001);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t6_clr", err_ack, 2'b00);

        // reset during B1 of the last retry; retry count must not survive reset
        ch0_value = 16'h0999; ch0_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0;
        expect_txn("t7a", 8'h00, 8'h09, 8'h99, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        expect_txn("t7b", 8'h00, 8'h09, 8'h99, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        expect_txn("t7c", 8'h00, 8'h09, 8'h99, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1 check("t7_async_rst", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t7_post_rst", all_outs(), 32'd0);
        ch0_value = 16'h0999; ch0_wr = 1'b1;
        @(negedge clk);
        ch0_wr = 1'b0;
        expect_txn("t7d", 8'h00, 8'h09, 8'h99, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t7d_retry", {pending, err_ack}, 4'b0100);
        expect_txn("t7e", 8'h00, 8'h09, 8'h99, 0, 0, 2'b00, 0, 0, 0, 0, 3);
        check("t7e_done", {pending, err_ack}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Shares the single MCP47FEB I2C DAC between two channel requesters (CH0 → DAC0 register, CH1 → DAC1 register).
- Coalesces requests (latest value wins), arbitrates round-robin, and sequences one I2C write transaction per update on the i2c_master cmd/data_in stream handshake.
- Retries on missed ACK and reports sticky per-channel errors.
- Sits between the application logic and the i2c_master instance; replaces ad-hoc DAC sequencing.

Parameters:
- DEV_ADDR, 7'h60, 7-bit I2C address of the MCP47FEB.
- MAX_RETRY, 2, retries after a missed ACK before dropping the update (0 = no retry).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch0_value  in  16  new DAC0 code
- ch0_wr  in  1  one-cycle strobe: capture ch0_value
- ch1_value  in  16  new DAC1 code
- ch1_wr  in  1  one-cycle strobe: capture ch1_value
- err_clr  in  1  clears err_ack
- pending  out  2  per-channel update outstanding
- busy  out  1  FSM not in IDLE
- err_ack  out  2  sticky: channel update dropped after retries exhausted
- cmd_address  out  7  to i2c_master
- cmd_start, cmd_write_multiple, cmd_stop  out  1 each  to i2c_master
- cmd_valid  out  1  to i2c_master
- cmd_ready  in  1  from i2c_master
- data_in  out  8  to i2c_master
- data_in_valid, data_in_last  out  1 each  to i2c_master
- data_in_ready  in  1  from i2c_master
- i2c_busy  in  1  i2c_master busy
- missed_ack  in  1  i2c_master missed_ack

Behaviour:
- Reset (async, rst_n=0): all outputs 0; holding regs 0; pending=0; rr pointer=CH0; FSM=IDLE; retry count=0.
- Capture: chN_wr=1 loads holding[N]←chN_value and sets pending[N] on the next edge. A write in the same cycle as the grant clear wins: pending stays 1 and holding takes the new value.
- Arbitration (IDLE only):
  - One pending bit set → grant that channel.
  - Both set → grant the channel not served last.
  - Grant edge: tx←holding[g]; clear pending[g]; FSM→CMD.
- States:
  - CMD: cmd_valid=1, cmd_address=DEV_ADDR, start/write_multiple/stop=1. Held until cmd_valid&cmd_ready; next edge drops cmd_valid and enters B0.
  - B0: data_in={4'b0,g,2'b00,1'b0} (5-bit register index, write cmd 00, 0).
  - B1: data_in=tx[15:8].
  - B2: data_in=tx[7:0], data_in_last=1.
  - B0–B2: data_in_valid=1, data held stable until data_in_valid&data_in_ready; advance on that edge. Exactly one byte is accepted per handshake.
  - WAIT: entered after the B2 accept; outputs idle. A missed_ack pulse during CMD..WAIT is latched in nack_seen. Exits when i2c_busy=0 and at least 2 cycles have elapsed in WAIT, then goes to DONE.
  - DONE (1 cycle):
    - nack_seen=0: retry←0, rr←g.
    - nack_seen=1 and retry<MAX_RETRY: retry++, set pending[g] (holding unchanged unless newer write).
    - Otherwise: err_ack[g]←1, retry←0, rr←g.
    - Clear nack_seen; →IDLE.
- Minimum transaction latency from grant: CMD+3 bytes+WAIT; no fixed bound (depends on handshakes).
- Writes during a transaction only update holding/pending; tx is never modified mid-transaction.
- err_clr clears err_ack the next edge; simultaneous set wins.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package dac_pkg holds:
  - the MCP47FEB address constant
  - the register indices DAC0=5'd0 and DAC1=5'd1
  - the write/read command codes 2'b00 and 2'b11
  - the FSM state encoding
- One natural sub-module: dac_rr_arbiter (2-input round-robin, pending+last → grant/valid). Everything else stays in the top module.

Test Plan:
- Single write: ch0_wr with 16'h0ABC, always-ready master → one cmd (addr 7'h60, start/stop/write_multiple=1), bytes 8'h00, 8'h0A, 8'hBC with last on 8'hBC only; pending=0 and busy=0 after DONE.
- Coalescing: ch1_wr with 16'h1111 then 16'h2222 before grant → one transaction, bytes 8'h08, 8'h22, 8'h22.
- Round-robin: both channels written in the same cycle, with values 16'h0001 and 16'h0002 → CH0 transaction first, then CH1; repeat both → CH1 first.
- Mid-transaction write: ch0_wr with 16'h0123 while CH0 is in B1 with tx 16'h0ABC → current bytes 8'h0A, 8'hBC unchanged; a second CH0 transaction sends 8'h01, 8'h23.
- Backpressure/NACK: data_in_ready held low for 5 cycles → data_in stable; missed_ack pulsed every transaction with MAX_RETRY=2 → 3 transactions, then err_ack=2'b01; err_clr → 2'b00.
- Reset mid-transaction: rst_n low during B1 → all outputs 0 asynchronously; after release → IDLE with no stale retry.
